// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM states,
// PC step sizes, the prefetch buffer entry layout and PC alignment.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DISCARD = 2'd1,
        ST_HOLD    = 2'd2
    } fetch_state_e;

    localparam logic [31:0] ARM_STEP   = 32'd4;
    localparam logic [31:0] THUMB_STEP = 32'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        thumb;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [31:0] align_pc(input logic [31:0] pc, input logic thumb);
        return thumb ? {pc[31:1], 1'b0} : {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched instructions; clear wins over push.
// Updates on the falling clock edge like the rest of the fetch stage.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  fetch_entry_t             wdata_i,
    output fetch_entry_t             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = fetch_entry_t'(mem_q[rd_ptr_q]);

    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i && !empty_o && !clear_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(negedge clock_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(negedge clock_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // A returning word must always find a free slot; one request in flight guarantees it.
    assert property (@(negedge clock_i) disable iff (reset_i) !(push_i && full_o && !clear_i));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, single-outstanding memory
// read handshake, prefetch buffer and redirect handling with wrong-path discard.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          BUF_DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        redirect_thumb,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_halfword,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic        fetch_thumb,
    output logic [1:0]  dbg_state
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             thumb_q, thumb_d;
    logic [31:0]      disc_addr_q, disc_addr_d;
    logic             disc_half_q, disc_half_d;

    logic             push, pop, buf_full, buf_empty;
    logic [CNT_W-1:0] buf_count, occ_next;
    fetch_entry_t     push_entry, head;

    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clock_i (clock),
        .reset_i (reset),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (redirect),
        .wdata_i (push_entry),
        .head_o  (head),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .count_o (buf_count)
    );

    assign dbg_state    = state_q;
    // While discarding, the abandoned request's address stays on the bus until it completes.
    assign mem_req      = !reset && (state_q != ST_HOLD);
    assign mem_addr     = (state_q == ST_DISCARD) ? disc_addr_q : pc_q;
    assign mem_halfword = (state_q == ST_DISCARD) ? disc_half_q : thumb_q;

    assign fetch_valid  = !buf_empty && !reset;
    assign fetch_pc     = fetch_valid ? head.pc    : 32'h0;
    assign fetch_instr  = fetch_valid ? head.instr : 32'h0;
    assign fetch_thumb  = fetch_valid ? head.thumb : 1'b0;

    assign pop  = fetch_valid && !stall;
    assign push = mem_req && mem_ready && (state_q == ST_FETCH) && !redirect;

    assign push_entry.pc    = pc_q;
    assign push_entry.instr = thumb_q ? {16'h0, mem_rdata[15:0]} : mem_rdata;
    assign push_entry.thumb = thumb_q;

    assign occ_next = buf_count + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        thumb_d     = thumb_q;
        disc_addr_d = disc_addr_q;
        disc_half_d = disc_half_q;
        if (redirect) begin
            pc_d    = align_pc(redirect_pc, redirect_thumb);
            thumb_d = redirect_thumb;
            if (mem_req && !mem_ready) begin
                state_d = ST_DISCARD;
                if (state_q == ST_FETCH) begin
                    disc_addr_d = pc_q;
                    disc_half_d = thumb_q;
                end
            end else begin
                state_d = ST_FETCH;
            end
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (mem_ready) begin
                        pc_d    = pc_q + (thumb_q ? THUMB_STEP : ARM_STEP);
                        state_d = (occ_next < DEPTH_C) ? ST_FETCH : ST_HOLD;
                    end
                end
                ST_DISCARD: begin
                    if (mem_ready) state_d = (occ_next < DEPTH_C) ? ST_FETCH : ST_HOLD;
                end
                ST_HOLD: begin
                    if (occ_next < DEPTH_C) state_d = ST_FETCH;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_VECTOR;
            thumb_q     <= 1'b0;
            disc_addr_q <= 32'h0;
            disc_half_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            thumb_q     <= thumb_d;
            disc_addr_q <= disc_addr_d;
            disc_half_q <= disc_half_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the fetch stage.
module tb_fetch_unit;

    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam int          DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset, stall, redirect, redirect_thumb, mem_ready;
    logic [31:0] redirect_pc, mem_rdata;
    logic        mem_req, mem_halfword, fetch_valid, fetch_thumb;
    logic [31:0] mem_addr, fetch_instr, fetch_pc;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    fetch_unit #(.RESET_VECTOR(RV), .BUF_DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .redirect_thumb (redirect_thumb),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_halfword   (mem_halfword),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .fetch_valid    (fetch_valid),
        .fetch_instr    (fetch_instr),
        .fetch_pc       (fetch_pc),
        .fetch_thumb    (fetch_thumb),
        .dbg_state      (dbg_state)
    );

    // Clock: state commits on the falling edge; the bench drives after the rising edge.
    initial forever #5 clock = ~clock;

    // Reference model: a queue of buffered instructions and one request descriptor.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        thumb;
    } ent_t;

    ent_t        m_buf[$];
    logic [31:0] m_pc;
    logic        m_thumb;
    logic        m_req_active;
    logic [31:0] m_req_addr;
    logic        m_req_half;
    logic        m_req_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] align(input logic [31:0] a, input logic th);
        return th ? (a & 32'hFFFF_FFFE) : (a & 32'hFFFF_FFFC);
    endfunction

    task automatic model_issue();
        m_req_active = 1'b1;
        m_req_addr   = m_pc;
        m_req_half   = m_thumb;
        m_req_drop   = 1'b0;
    endtask

    task automatic model_compare();
        logic exp_req, exp_valid;
        exp_req   = !reset && m_req_active;
        exp_valid = !reset && (m_buf.size() > 0);
        check("mem_req", 32'(mem_req), 32'(exp_req));
        if (exp_req) begin
            check("mem_addr", mem_addr, m_req_addr);
            check("mem_halfword", 32'(mem_halfword), 32'(m_req_half));
        end
        check("fetch_valid", 32'(fetch_valid), 32'(exp_valid));
        check("fetch_pc", fetch_pc, exp_valid ? m_buf[0].pc : 32'h0);
        check("fetch_instr", fetch_instr, exp_valid ? m_buf[0].instr : 32'h0);
        check("fetch_thumb", 32'(fetch_thumb), exp_valid ? 32'(m_buf[0].thumb) : 32'h0);
    endtask

    task automatic model_edge();
        logic popped, accepted;
        ent_t e;
        if (reset) begin
            m_buf.delete();
            m_pc    = RV;
            m_thumb = 1'b0;
            model_issue();
            return;
        end
        popped   = (m_buf.size() > 0) && !stall;
        accepted = m_req_active && mem_ready;
        if (redirect) begin
            m_buf.delete();
            m_pc    = align(redirect_pc, redirect_thumb);
            m_thumb = redirect_thumb;
            if (m_req_active && !mem_ready) m_req_drop = 1'b1;
            else model_issue();
        end else begin
            if (popped) void'(m_buf.pop_front());
            if (accepted && !m_req_drop) begin
                e.pc    = m_req_addr;
                e.instr = m_req_half ? {16'h0, mem_rdata[15:0]} : mem_rdata;
                e.thumb = m_req_half;
                m_buf.push_back(e);
                m_pc = m_pc + (m_thumb ? 32'd2 : 32'd4);
            end
            if (accepted || !m_req_active) begin
                if (m_buf.size() < DEPTH) model_issue();
                else m_req_active = 1'b0;
            end
        end
    endtask

    task automatic drive_cycle(input logic rst, input logic stl, input logic rdr,
                               input logic [31:0] rpc, input logic rth, input logic rdy);
        @(posedge clock);
        reset          = rst;
        stall          = stl;
        redirect       = rdr;
        redirect_pc    = rpc;
        redirect_thumb = rth;
        mem_ready      = rdy;
        mem_rdata      = $urandom;
        #1;
        model_compare();
        model_edge();
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        redirect_thumb = 1'b0; mem_ready = 1'b0; mem_rdata = '0;

        // Back-to-back ARM fetch after reset
        repeat (2) drive_cycle(1, 0, 0, 0, 0, 1);
        repeat (8) drive_cycle(0, 0, 0, 0, 0, 1);

        // Stall fills the buffer, fetch holds, release drains it
        repeat (2) drive_cycle(1, 0, 0, 0, 0, 1);
        drive_cycle(0, 0, 0, 0, 0, 1);
        repeat (4) drive_cycle(0, 1, 0, 0, 0, 1);
        repeat (5) drive_cycle(0, 0, 0, 0, 0, 1);

        // Redirect while a request is stuck: returned data dropped
        repeat (2) drive_cycle(1, 0, 0, 0, 0, 1);
        drive_cycle(0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 1, 32'h100, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0);
        repeat (5) drive_cycle(0, 0, 0, 0, 0, 1);

        // Thumb redirect with misaligned target
        drive_cycle(0, 0, 1, 32'h203, 1, 1);
        repeat (6) drive_cycle(0, 0, 0, 0, 0, 1);

        // Redirect and pop on the same edge with a full buffer
        repeat (2) drive_cycle(1, 0, 0, 0, 0, 1);
        repeat (4) drive_cycle(0, 1, 0, 0, 0, 1);
        drive_cycle(0, 0, 1, 32'h400, 0, 1);
        repeat (4) drive_cycle(0, 0, 0, 0, 0, 1);

        // Reset in the middle of a stuck request
        repeat (2) drive_cycle(0, 0, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0);
        repeat (2) drive_cycle(0, 0, 0, 0, 0, 0);
        repeat (3) drive_cycle(0, 0, 0, 0, 0, 1);

        // PC wrap at the top of the address space, ARM and Thumb
        drive_cycle(0, 0, 1, 32'hFFFF_FFFC, 0, 1);
        repeat (4) drive_cycle(0, 0, 0, 0, 0, 1);
        drive_cycle(0, 0, 1, 32'hFFFF_FFFF, 1, 1);
        repeat (4) drive_cycle(0, 0, 0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            drive_cycle($urandom_range(63) == 0,
                        $urandom_range(2) == 0,
                        $urandom_range(11) == 0,
                        ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom,
                        1'($urandom_range(1)),
                        $urandom_range(1) == 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
